// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-file write-side front end.
package regfile_pkg;
  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [RF_AW-1:0] wa;
    logic [RF_DW-1:0] wd;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO of pending long-latency writebacks, with an age-ordered
// view of every slot (index 0 = head/oldest) so readers can forward from it.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  wb_entry_t              i_push_data,
  input  logic                   i_pop,
  output wb_entry_t              o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output wb_entry_t [DEPTH-1:0]  o_ent,
  output logic [DEPTH-1:0]       o_vld
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  wb_entry_t     r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  // Storage is not reset; occupancy is tracked solely by r_count.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_view
    assign o_ent[g] = r_mem[r_rd_ptr + PW'(g)];
    assign o_vld[g] = ((PW+1)'(g) < r_count);
  end
endmodule

// File: rtl/regfile_writer.sv
// Write-port arbiter for the register file: ALU first, then queued/bypassed
// long-latency results, plus a pending-destination scoreboard.
// Forwarding from uncommitted writes is compiled in when REGFILE_WRITER_FWD_EN is defined.
module regfile_writer
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             alu_valid,
  input  logic [RF_AW-1:0] alu_wa,
  input  logic [RF_DW-1:0] alu_wd,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [RF_AW-1:0] mem_wa,
  input  logic [RF_DW-1:0] mem_wd,
  input  logic             claim_valid,
  input  logic [RF_AW-1:0] claim_wa,
  output logic [31:0]      busy_mask,
  output logic             we3,
  output logic [RF_AW-1:0] wa3,
  output logic [RF_DW-1:0] wd3,
  output wb_src_e          o_wb_src,
  input  logic [RF_AW-1:0] fwd_ra1,
  input  logic [RF_AW-1:0] fwd_ra2,
  output logic             fwd_hit1,
  output logic             fwd_hit2,
  output logic [RF_DW-1:0] fwd_data1,
  output logic [RF_DW-1:0] fwd_data2
);
  logic             r_we;
  logic [RF_AW-1:0] r_wa;
  logic [RF_DW-1:0] r_wd;
  wb_src_e          r_src;
  logic [31:0]      r_busy;

  logic                  w_full;
  logic                  w_empty;
  wb_entry_t             w_head;
  wb_entry_t [DEPTH-1:0] w_ent;
  logic [DEPTH-1:0]      w_vld;
  logic                  w_mem_acc;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_ld_vld;
  wb_entry_t             w_ld;
  wb_src_e               w_ld_src;
  logic [31:0]           w_busy_nxt;

  // mem handshake: a result transfers on a rising edge where mem_valid && mem_ready;
  // mem_ready depends only on registered occupancy, so it never reacts to a same-cycle pop.
  assign mem_ready = reset_n && !w_full;
  assign w_mem_acc = mem_valid && mem_ready;

  always_comb begin
    w_ld_vld = 1'b0;
    w_ld     = '0;
    w_ld_src = SRC_ALU;
    w_pop    = 1'b0;
    if (alu_valid) begin
      w_ld_vld = 1'b1;
      w_ld.wa  = alu_wa;
      w_ld.wd  = alu_wd;
    end else if (!w_empty) begin
      w_ld_vld = 1'b1;
      w_ld     = w_head;
      w_ld_src = SRC_MEM;
      w_pop    = 1'b1;
    end else if (w_mem_acc) begin
      w_ld_vld = 1'b1;
      w_ld.wa  = mem_wa;
      w_ld.wd  = mem_wd;
      w_ld_src = SRC_MEM;
    end
  end

  // Only a bypass (port free and FIFO empty) skips the queue.
  assign w_push = w_mem_acc && (alu_valid || !w_empty);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (clk),
    .i_rst_n     (reset_n),
    .i_push      (w_push),
    .i_push_data ('{wa: mem_wa, wd: mem_wd}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_ent       (w_ent),
    .o_vld       (w_vld)
  );

  // A claim in the same cycle as a retirement to that register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_ld_vld && (w_ld_src == SRC_MEM)) w_busy_nxt[w_ld.wa] = 1'b0;
    if (claim_valid) w_busy_nxt[claim_wa] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we   <= 1'b0;
      r_wa   <= '0;
      r_wd   <= '0;
      r_src  <= SRC_ALU;
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_we   <= w_ld_vld && (w_ld.wa != '0);
      if (w_ld_vld) begin
        r_wa  <= w_ld.wa;
        r_wd  <= w_ld.wd;
        r_src <= w_ld_src;
      end
    end
  end

  assign we3       = r_we;
  assign wa3       = r_wa;
  assign wd3       = r_wd;
  assign o_wb_src  = r_src;
  assign busy_mask = r_busy;

`ifdef REGFILE_WRITER_FWD_EN
  // Later matches override earlier ones: output stage, then FIFO head to tail.
  function automatic logic [RF_DW:0] fwd_lookup(
    input logic [RF_AW-1:0]    ra,
    input logic                out_we,
    input logic [RF_AW-1:0]    out_wa,
    input logic [RF_DW-1:0]    out_wd,
    input wb_entry_t [DEPTH-1:0] ent,
    input logic [DEPTH-1:0]    vld
  );
    logic [RF_DW:0] res;
    res = '0;
    if (out_we && (out_wa == ra)) res = {1'b1, out_wd};
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (ent[i].wa == ra)) res = {1'b1, ent[i].wd};
    end
    if (ra == '0) res = '0;
    return res;
  endfunction

  assign {fwd_hit1, fwd_data1} = fwd_lookup(fwd_ra1, r_we, r_wa, r_wd, w_ent, w_vld);
  assign {fwd_hit2, fwd_data2} = fwd_lookup(fwd_ra2, r_we, r_wa, r_wd, w_ent, w_vld);
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd_ra1, fwd_ra2, w_ent, w_vld};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif
endmodule

// File: tb/tb_regfile_writer.sv
// Directed bench for regfile_writer: commits are checked against an expected queue.
module tb_regfile_writer;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_wa;
  logic [31:0] mem_wd;
  logic        claim_valid;
  logic [4:0]  claim_wa;
  logic [31:0] busy_mask;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  wb_src_e     o_wb_src;
  logic [4:0]  fwd_ra1, fwd_ra2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;

  logic [36:0] exp_q[$];
  logic [36:0] pend_q[$];
  int n_chk = 0;
  int n_err = 0;

  regfile_writer #(.DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .claim_valid(claim_valid), .claim_wa(claim_wa), .busy_mask(busy_mask),
    .we3(we3), .wa3(wa3), .wd3(wd3), .o_wb_src(o_wb_src),
    .fwd_ra1(fwd_ra1), .fwd_ra2(fwd_ra2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every committed write must be the next expected one
  always @(negedge clk) begin
    if (reset_n === 1'b1 && we3 === 1'b1) begin
      n_chk++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_write: observed=r%0d=%0h expected=none", wa3, wd3);
      end
      if (exp_q.size() != 0) begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("commit", {27'b0, wa3, wd3}, {27'b0, e});
      end
    end
  end

  // drivers
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
    mem_valid = 1'b0; mem_wa = '0; mem_wd = '0;
    claim_valid = 1'b0; claim_wa = '0;
    fwd_ra1 = '0; fwd_ra2 = '0;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    int  k;
    logic acc;
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) step();
    chk("ready_in_reset", mem_ready, 0);
    reset_n = 1'b1;
    #1;
    chk("reset_we3", we3, 0);
    chk("reset_wa3", wa3, 0);
    chk("reset_wd3", wd3, 0);
    chk("reset_busy", busy_mask, 0);
    chk("ready_after_reset", mem_ready, 1);
    @(negedge clk);

    // bypass path with scoreboard clear
    claim_valid = 1'b1; claim_wa = 5'd5;
    step();
    chk("busy5_set", busy_mask, 32'h20);
    claim_valid = 1'b0;
    mem_valid = 1'b1; mem_wa = 5'd5; mem_wd = 32'h1234;
    exp_q.push_back({5'd5, 32'h1234});
    step();
    mem_valid = 1'b0;
    chk("bypass_we3", we3, 1);
    chk("bypass_wa3", wa3, 5);
    chk("bypass_src", o_wb_src, SRC_MEM);
    chk("bypass_busy_clear", busy_mask, 0);

    // ALU and mem in the same cycle: ALU first, mem next
    alu_valid = 1'b1; alu_wa = 5'd3; alu_wd = 32'hA;
    mem_valid = 1'b1; mem_wa = 5'd7; mem_wd = 32'hB;
    claim_valid = 1'b1; claim_wa = 5'd7;
    exp_q.push_back({5'd3, 32'hA});
    exp_q.push_back({5'd7, 32'hB});
    step();
    idle_inputs();
    chk("alu_first_wa3", wa3, 3);
    chk("busy7_pending", busy_mask, 32'h80);
    step();
    chk("mem_second_wa3", wa3, 7);
    chk("busy7_clear", busy_mask, 0);
    step();
    chk("idle_we3", we3, 0);

    // FIFO fill under sustained ALU traffic, then ordered drain
    k = 0;
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1'b1; alu_wa = 5'(10 + c); alu_wd = 32'h100 + 32'(c);
      exp_q.push_back({alu_wa, alu_wd});
      mem_valid = (k < 5); mem_wa = 5'(20 + k); mem_wd = 32'h200 + 32'(k);
      chk("ready_fill", mem_ready, (c < 4));
      acc = mem_valid && mem_ready;
      if (acc) pend_q.push_back({mem_wa, mem_wd});
      step();
      if (acc) k++;
    end
    alu_valid = 1'b0;
    while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
    chk("ready_full_with_pop", mem_ready, 0);
    for (int c = 0; c < 20 && k < 5; c++) begin
      mem_valid = 1'b1; mem_wa = 5'(20 + k); mem_wd = 32'h200 + 32'(k);
      acc = mem_valid && mem_ready;
      if (acc) exp_q.push_back({mem_wa, mem_wd});
      step();
      if (acc) k++;
    end
    chk("mem_all_accepted", k, 5);
    idle_inputs();
    drain("fifo_drain");

    // claim beats a same-cycle retirement; r0 handling
    claim_valid = 1'b1; claim_wa = 5'd9;
    step();
    mem_valid = 1'b1; mem_wa = 5'd9; mem_wd = 32'h99;
    exp_q.push_back({5'd9, 32'h99});
    step();
    chk("claim_wins", busy_mask, 32'h200);
    claim_valid = 1'b0;
    mem_wd = 32'h9A;
    exp_q.push_back({5'd9, 32'h9A});
    step();
    chk("busy9_clear", busy_mask, 0);
    idle_inputs();
    claim_valid = 1'b1; claim_wa = 5'd0;
    alu_valid = 1'b1; alu_wa = 5'd0; alu_wd = 32'hDEAD;
    step();
    idle_inputs();
    chk("claim_r0", busy_mask, 0);
    chk("write_r0_we3", we3, 0);

    // forwarding from queued entries
    alu_valid = 1'b1; alu_wa = 5'd11; alu_wd = 32'h111;
    mem_valid = 1'b1; mem_wa = 5'd4; mem_wd = 32'h1;
    exp_q.push_back({5'd11, 32'h111});
    step();
    alu_wa = 5'd12; alu_wd = 32'h112; mem_wd = 32'h2;
    exp_q.push_back({5'd12, 32'h112});
    step();
    mem_valid = 1'b0; alu_wa = 5'd13; alu_wd = 32'h113;
    fwd_ra1 = 5'd4; fwd_ra2 = 5'd0;
    #1;
`ifdef REGFILE_WRITER_FWD_EN
    chk("fwd_young_hit", fwd_hit1, 1);
    chk("fwd_young_data", fwd_data1, 32'h2);
    chk("fwd_r0_hit", fwd_hit2, 0);
    fwd_ra2 = 5'd12;
    #1;
    chk("fwd_out_hit", fwd_hit2, 1);
    chk("fwd_out_data", fwd_data2, 32'h112);
`else
    chk("fwd_off_hit1", fwd_hit1, 0);
    chk("fwd_off_data1", fwd_data1, 0);
    chk("fwd_off_hit2", fwd_hit2, 0);
`endif
    exp_q.push_back({5'd13, 32'h113});
    step();
    idle_inputs();
    exp_q.push_back({5'd4, 32'h1});
    exp_q.push_back({5'd4, 32'h2});
    drain("fwd_drain");

    // asynchronous reset with three queued writes and pending claims
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1'b1; alu_wa = 5'(25 + c); alu_wd = 32'h300 + 32'(c);
      exp_q.push_back({alu_wa, alu_wd});
      mem_valid = 1'b1; mem_wa = 5'(14 + c); mem_wd = 32'h400 + 32'(c);
      claim_valid = 1'b1; claim_wa = 5'(14 + c);
      step();
    end
    idle_inputs();
    chk("busy_before_reset", busy_mask, 32'h1C000);
    #2 reset_n = 1'b0;
    #1;
    chk("async_we3", we3, 0);
    chk("async_busy", busy_mask, 0);
    chk("async_ready", mem_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) step();
    chk("nothing_after_reset", exp_q.size(), 0);
    chk("busy_after_reset", busy_mask, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_writer.md
# regfile_writer

Write-side front end for the three-ported register file: owns the single write port (`we3`/`wa3`/`wd3`) and arbitrates between the single-cycle ALU writeback path and a long-latency (load/multiply) writeback path. Long-latency results are queued in a small FIFO whenever the ALU path holds the port. A pending-destination scoreboard lets decode stall on unresolved destinations. Optional forwarding ports expose queued, not-yet-committed write data to readers.

## Interface
- `DEPTH`, 4, long-latency FIFO entries; power of two, ≥2.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result present this cycle; always accepted, no ready.
- `alu_wa`  in  5  ALU destination register.
- `alu_wd`  in  32  ALU result.
- `mem_valid`  in  1  long-latency result offered.
- `mem_ready`  out  1  long-latency result accepted when `mem_valid && mem_ready`.
- `mem_wa`  in  5  long-latency destination.
- `mem_wd`  in  32  long-latency result.
- `claim_valid`  in  1  decode issued a long-latency op.
- `claim_wa`  in  5  its destination.
- `busy_mask`  out  32  bit n set means a long-latency write to rn is pending.
- `we3`, `wa3`, `wd3`  out  1/5/32  registered outputs to the register-file write port.
- `fwd_ra1`, `fwd_ra2`  in  5  forwarding queries.
- `fwd_hit1`, `fwd_hit2`  out  1  query matches an uncommitted write.
- `fwd_data1`, `fwd_data2`  out  32  forwarded value.

## Operation
- Output stage: one register holding {we3, wa3, wd3, src}. It is loaded every cycle using this priority:
  1. `alu_valid` loads the ALU result.
  2. Otherwise, a non-empty FIFO loads the FIFO head and pops it.
  3. Otherwise, an accepted mem transfer loads it directly (FIFO bypass).
  4. Otherwise `we3` = 0.
- An accepted mem transfer is pushed into the FIFO unless it took the bypass path.
- `mem_ready` = FIFO not full, based on the registered count only. It is deasserted at full even if a pop occurs the same cycle.
- A write to r0 is loaded with `we3` = 0. The scoreboard is still cleared.
- Scoreboard:
  - `claim_valid` sets `busy_mask[claim_wa]`.
  - Loading a mem-sourced entry into the output stage clears `busy_mask[wa]`.
  - If a claim and a clear hit the same register in one cycle, the set wins.
  - `busy_mask[0]` is always 0.
- Ordering contract: decode must not issue an ALU op whose destination is busy. The block does not reorder writes.
- Forwarding (combinational):
  - A query hits on a matching valid FIFO entry or on the output stage with `we3` = 1.
  - Priority is youngest first: FIFO tail, then toward the head, then the output stage.
  - A query on r0 never hits.

## Timing
- Reset values: `we3`=0, `wa3`=0, `wd3`=0, `busy_mask`=0, FIFO empty, `mem_ready`=0 while `reset_n` is low. `mem_ready` is 1 in the first cycle after release.
- ALU latency: `alu_valid` in cycle t gives `we3`=1 in cycle t+1. The register file commits at the end of t+1.
- Mem latency via bypass: 1 cycle. Via FIFO: 1 + number of cycles the port was taken by the ALU or older entries.
- With the FIFO at DEPTH and `alu_valid` held high, `mem_ready` stays 0 and nothing drains.
- Reset mid-operation discards all queued writes and pending claims immediately (asynchronous).
- The FIFO pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

## Configuration
- `REGFILE_WRITER_FWD_EN` defined: forwarding logic is compiled in.
- Undefined: `fwd_hit*` = 0 and `fwd_data*` = 0; the query inputs are ignored. Ports remain present.

## Structure
- Shared package `regfile_pkg`:
  - `RF_AW`=5 and `RF_DW`=32.
  - `wb_src_e` {SRC_ALU, SRC_MEM}.
  - Struct `wb_entry_t` {wa, wd}.
- One sub-module, `wb_fifo`: parameterised DEPTH FIFO of `wb_entry_t` with push, pop, full, empty and a flat entry/valid view for forwarding.

## Test plan
- Reset, then `mem_valid` with wa=5, wd=0x1234 and no ALU activity: next cycle `we3`=1, `wa3`=5, `wd3`=0x1234, and `busy_mask[5]` clears in that cycle.
- `alu_valid` (r3=0xA) and `mem_valid` (r7=0xB) together: cycle+1 writes r3=0xA, cycle+2 writes r7=0xB.
- `alu_valid` held for 6 cycles while mem offers 5 results with DEPTH=4: `mem_ready` drops after 4 pushes, and all results then drain in order once ALU traffic stops.
- `claim_valid` on r9 together with a retiring mem write to r9: `busy_mask[9]` stays 1. A claim on r0 leaves `busy_mask`=0.
- With the macro defined and the FIFO holding r4=0x1 (older) and r4=0x2 (younger): query `fwd_ra1`=4 gives hit=1, data=0x2. Query r0 gives hit=0. With the macro undefined, hit=0.
- `reset_n` pulsed low while the FIFO holds 3 entries: `we3` goes 0 immediately, no queued write commits afterward, and `busy_mask`=0.
